cpu_sequencer: RTL and testbench

//  Multi-cycle execution sequencer for the processor datapath. Steps each instruction through

---
 rtl/cpu_sequencer_pkg.sv | 23 ++
 rtl/cpu_sequencer_rise_detector.sv | 22 ++
 rtl/cpu_sequencer.sv | 113 +++++++++++
 tb/tb_cpu_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared phase encodings and decode constants for the multi-cycle sequencer.
// The processor and benches decode the phase output with these values.
package cpu_sequencer_pkg;

    localparam int PHASE_W = 3;

    localparam logic [PHASE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [PHASE_W-1:0] ST_FETCH     = 3'd1;
    localparam logic [PHASE_W-1:0] ST_DECODE    = 3'd2;
    localparam logic [PHASE_W-1:0] ST_EXECUTE   = 3'd3;
    localparam logic [PHASE_W-1:0] ST_MEMORY    = 3'd4;
    localparam logic [PHASE_W-1:0] ST_WRITEBACK = 3'd5;
    localparam logic [PHASE_W-1:0] ST_HALT      = 3'd6;

    localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'd62;
    localparam logic [1:0] SRC_RAM             = 2'd1;

    // Loads and stores both need a MEMORY phase.
    function automatic logic needs_memory(input logic ramconfig, input logic [1:0] regsource);
        return ramconfig || (regsource == SRC_RAM);
    endfunction

endpackage

// File: rtl/cpu_sequencer_rise_detector.sv
// Registers a slow level input (board switch) and emits a one-cycle pulse on its
// rising edge.
module rise_detector (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH..WRITEBACK, gates PC / register / RAM
// writes, supports free-run, single-step and halt, and counts active cycles and retirements.
//
//  state     | meaning
//  IDLE      | waiting for run or an accepted step edge
//  FETCH     | instruction word latched (ir_load)
//  DECODE    | opcode inspected for halt
//  EXECUTE   | ALU work; choose MEMORY or WRITEBACK
//  MEMORY    | RAM access, write strobe on entry only, stall on mem_ready
//  WRITEBACK | commit: PC update and register write, one cycle
//  HALT      | stopped until reset
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int         COUNT_WIDTH = 32,
    parameter logic [5:0] HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   step,
    input  logic [0:31]            instruction,
    input  logic                   ramconfig,
    input  logic                   regbankconfig,
    input  logic [1:0]             regsource,
    input  logic                   mem_ready,
    output logic                   ir_load,
    output logic                   pc_enable,
    output logic                   regbank_wenable,
    output logic                   ram_wenable,
    output logic [PHASE_W-1:0]     phase,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    logic [PHASE_W-1:0] state;
    logic [PHASE_W-1:0] state_nxt;
    logic               mem_entered;
    logic               step_rise;
    logic               unused_instr;

    assign unused_instr = ^instruction[6:31];

    rise_detector u_step_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .level   (step),
        .rise    (step_rise)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (run || step_rise) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH:  state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (instruction[0:5] == HALT_OPCODE) begin
                    state_nxt = ST_HALT;
                end else begin
                    state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (needs_memory(ramconfig, regsource)) begin
                    state_nxt = ST_MEMORY;
                end else begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (mem_ready) begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            // run is sampled only here, so a started instruction always commits fully
            ST_WRITEBACK: state_nxt = run ? ST_FETCH : ST_IDLE;
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            mem_entered   <= 1'b0;
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            state       <= state_nxt;
            // Low only on the first MEMORY cycle, so a stalled store writes once.
            mem_entered <= (state == ST_MEMORY);
            if ((state != ST_IDLE) && (state != ST_HALT)) begin
                cycle_count <= cycle_count + 1'b1;
            end
            if (state == ST_WRITEBACK) begin
                retired_count <= retired_count + 1'b1;
            end
        end
    end

    assign phase           = state;
    assign ir_load         = (state == ST_FETCH);
    assign pc_enable       = (state == ST_WRITEBACK);
    assign regbank_wenable = (state == ST_WRITEBACK) & regbankconfig;
    assign ram_wenable     = (state == ST_MEMORY) & ~mem_entered & ramconfig;
    assign halted          = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a table of single instructions in free-run mode,
// then hand sequences for stepping, run drop, halt hold and reset during MEMORY.
module tb_cpu_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [0:31] instruction = '0;
    logic        ramconfig = 1'b0;
    logic        regbankconfig = 1'b0;
    logic [1:0]  regsource = 2'd0;
    logic        mem_ready = 1'b1;
    logic        ir_load, pc_enable, regbank_wenable, ram_wenable, halted;
    logic [2:0]  phase;
    logic [31:0] cycle_count, retired_count;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    cpu_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .run             (run),
        .step            (step),
        .instruction     (instruction),
        .ramconfig       (ramconfig),
        .regbankconfig   (regbankconfig),
        .regsource       (regsource),
        .mem_ready       (mem_ready),
        .ir_load         (ir_load),
        .pc_enable       (pc_enable),
        .regbank_wenable (regbank_wenable),
        .ram_wenable     (ram_wenable),
        .phase           (phase),
        .halted          (halted),
        .cycle_count     (cycle_count),
        .retired_count   (retired_count)
    );

    typedef struct {
        logic [5:0] opcode;
        logic       ramconfig;
        logic       regbankconfig;
        logic [1:0] regsource;
        int         mem_wait;
        int         mem_cycles;
        int         exp_cycles;
        int         exp_ram;
        int         exp_rb;
        logic       exp_halt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        step = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget);
        int n;
        n = 0;
        while (phase !== p && n < budget) begin
            @(negedge clock);
            n++;
        end
        check($sformatf("wait_phase_%0d", p), phase, p);
    endtask

    function automatic logic [2:0] exp_phase(input vec_t v, input int k);
        if (k == 0) return 3'd1;
        if (k == 1) return 3'd2;
        if (v.exp_halt) return 3'd6;
        if (k == 2) return 3'd3;
        if (k < 3 + v.mem_cycles) return 3'd4;
        return 3'd5;
    endfunction

    initial begin
        int ram_p, rb_p, pc_p, waits, last;
        logic [2:0] ep;
        logic [2:0] step_seq[10];

        //            op     ram   rb    src   wait memc cyc  ram rb halt
        vecs[0] = '{6'd0,  1'b0, 1'b1, 2'd0, 0,   0,   4,   0,  1, 1'b0}; // R-type add
        vecs[1] = '{6'd18, 1'b1, 1'b0, 2'd0, 3,   4,   8,   1,  0, 1'b0}; // store, 3 stalls
        vecs[2] = '{6'd17, 1'b0, 1'b1, 2'd1, 0,   1,   5,   0,  1, 1'b0}; // load
        vecs[3] = '{6'd17, 1'b0, 1'b1, 2'd1, 2,   3,   7,   0,  1, 1'b0}; // load, 2 stalls
        vecs[4] = '{6'd62, 1'b1, 1'b1, 2'd1, 0,   0,   2,   0,  0, 1'b1}; // halt
        vecs[5] = '{6'd5,  1'b0, 1'b1, 2'd2, 0,   0,   4,   0,  1, 1'b0}; // non-RAM source
        vecs[6] = '{6'd18, 1'b1, 1'b0, 2'd0, 0,   1,   5,   1,  0, 1'b0}; // store, no stall

        // Reset state
        @(negedge clock);
        check("rst_phase", phase, 3'd0);
        check("rst_enables", {ir_load, pc_enable, regbank_wenable, ram_wenable, halted}, 5'd0);
        check("rst_cycle", cycle_count, 0);
        check("rst_retired", retired_count, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            instruction   = {vecs[i].opcode, 26'h155};
            ramconfig     = vecs[i].ramconfig;
            regbankconfig = vecs[i].regbankconfig;
            regsource     = vecs[i].regsource;
            run = 1'b1;
            ram_p = 0; rb_p = 0; pc_p = 0; waits = 0;
            last = vecs[i].exp_halt ? 2 : vecs[i].exp_cycles - 1;
            for (int k = 0; k <= last; k++) begin
                @(negedge clock);
                ep = exp_phase(vecs[i], k);
                check($sformatf("v%0d_phase_k%0d", i, k), phase, ep);
                check($sformatf("v%0d_irload_k%0d", i, k), ir_load, ep == 3'd1);
                ram_p += int'(ram_wenable);
                rb_p  += int'(regbank_wenable);
                pc_p  += int'(pc_enable);
                if (phase == 3'd4 && waits < vecs[i].mem_wait) begin
                    mem_ready = 1'b0;
                    waits++;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            if (vecs[i].exp_halt) begin
                repeat (20) begin
                    @(negedge clock);
                    pc_p += int'(pc_enable);
                    ram_p += int'(ram_wenable);
                    rb_p += int'(regbank_wenable);
                end
                check($sformatf("v%0d_halted", i), halted, 1'b1);
                check($sformatf("v%0d_phase_hold", i), phase, 3'd6);
                check($sformatf("v%0d_retired", i), retired_count, 0);
            end else begin
                @(negedge clock);
                check($sformatf("v%0d_next_fetch", i), phase, 3'd1);
                check($sformatf("v%0d_retired", i), retired_count, 1);
            end
            check($sformatf("v%0d_cycles", i), cycle_count, vecs[i].exp_cycles);
            check($sformatf("v%0d_ram_pulses", i), ram_p, vecs[i].exp_ram);
            check($sformatf("v%0d_rb_pulses", i), rb_p, vecs[i].exp_rb);
            check($sformatf("v%0d_pc_pulses", i), pc_p, vecs[i].exp_halt ? 0 : 1);
        end

        // Single step: step held high 10 cycles gives exactly one instruction.
        do_reset();
        instruction = {6'd0, 26'h0}; ramconfig = 1'b0; regbankconfig = 1'b1; regsource = 2'd0;
        step_seq = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        step = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("step_phase_k%0d", k), phase, step_seq[k]);
        end
        check("step_retired", retired_count, 1);
        check("step_cycles", cycle_count, 4);

        // A step edge arriving mid-instruction is ignored, not queued.
        step = 1'b0;
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        check("step2_fetch", phase, 3'd1);
        @(negedge clock);
        check("step2_decode", phase, 3'd2);
        step = 1'b0;
        @(negedge clock);
        check("step2_execute", phase, 3'd3);
        step = 1'b1;
        @(negedge clock);
        check("step2_writeback", phase, 3'd5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check($sformatf("step2_idle_k%0d", k), phase, 3'd0);
        end
        check("step2_retired", retired_count, 2);
        check("step2_cycles", cycle_count, 8);

        // run dropped during EXECUTE of a load: finish through WRITEBACK, then IDLE.
        do_reset();
        instruction = {6'd17, 26'h0}; ramconfig = 1'b0; regbankconfig = 1'b1; regsource = 2'd1;
        run = 1'b1;
        wait_phase(3'd3, 10);
        run = 1'b0;
        @(negedge clock);
        check("drop_memory", phase, 3'd4);
        @(negedge clock);
        check("drop_writeback", phase, 3'd5);
        check("drop_rb_we", regbank_wenable, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("drop_idle_k%0d", k), phase, 3'd0);
        end
        check("drop_retired", retired_count, 1);
        check("drop_cycles", cycle_count, 5);

        // Reset asserted during MEMORY kills the pending store immediately.
        do_reset();
        instruction = {6'd18, 26'h0}; ramconfig = 1'b1; regbankconfig = 1'b1; regsource = 2'd0;
        mem_ready = 1'b0;
        run = 1'b1;
        wait_phase(3'd4, 10);
        check("mrst_ram_we_before", ram_wenable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_phase", phase, 3'd0);
        check("mrst_enables", {ir_load, pc_enable, regbank_wenable, ram_wenable, halted}, 5'd0);
        check("mrst_cycle", cycle_count, 0);
        check("mrst_retired", retired_count, 0);
        @(negedge clock);
        check("mrst_ram_we_held", ram_wenable, 1'b0);
        reset_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
